// File: rtl/pool_pkg.sv
// Shared types and constants for the 1D max-pooling window generator.
// The output length helper returns 0 for illegal shapes so callers can reject them.
package pool_pkg;

   localparam int unsigned DATA_W = 32;
   localparam logic [DATA_W-1:0] PAD_VALUE = {1'b1, {(DATA_W - 1){1'b0}}};

   typedef enum logic [1:0] {LEAD, BODY, TRAIL} state_e;

   typedef struct packed {
      logic              pad;
      logic [DATA_W-1:0] data;
   } tap_entry_t;

   function automatic int pool_out_len(input int seq_len, input int kernel, input int stride,
                                       input int padding, input int dilation);
      int span;
      int plen;
      span = dilation * (kernel - 1) + 1;
      plen = seq_len + 2 * padding;
      if (stride < 1 || plen < span) return 0;
      return (plen - span) / stride + 1;
   endfunction

endpackage

// File: rtl/pool1d_tap_shreg.sv
// SPAN-deep {pad, data} shift register with KERNEL dilated taps, index 0 oldest.
// Taps show the post-shift view so a window can be captured on the same edge as its newest entry.
module pool1d_tap_shreg
   import pool_pkg::*;
#(
   parameter int unsigned SPAN     = 3,
   parameter int unsigned KERNEL   = 3,
   parameter int unsigned DILATION = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     shift_en,
   input  logic                     pad_ins,
   input  logic [DATA_W-1:0]        din,
   output logic [KERNEL*DATA_W-1:0] tap_data,
   output logic [KERNEL-1:0]        tap_pad
);

   localparam tap_entry_t PAD_ENTRY = '{pad: 1'b1, data: PAD_VALUE};

   tap_entry_t q   [SPAN];
   tap_entry_t nxt [SPAN];
   tap_entry_t new_entry;

   always_comb begin
      new_entry.pad  = pad_ins;
      new_entry.data = pad_ins ? PAD_VALUE : din;
      for (int i = 0; i < int'(SPAN) - 1; i++) begin
         nxt[i] = shift_en ? q[i+1] : q[i];
      end
      nxt[SPAN-1] = shift_en ? new_entry : q[SPAN-1];
   end

   always_comb begin
      tap_data = '0;
      tap_pad  = '0;
      for (int k = 0; k < int'(KERNEL); k++) begin
         tap_data[k*DATA_W +: DATA_W] = nxt[k*DILATION].data;
         tap_pad[k]                   = nxt[k*DILATION].pad;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(SPAN); i++) q[i] <= PAD_ENTRY;
      end else begin
         q <= nxt;
      end
   end

endmodule

// File: rtl/pool1d_window_gen.sv
// Streams padded rows through a tap shift register and emits one MaxPool1d window per output
// position as a packed lane vector with a pad mask.
module pool1d_window_gen
   import pool_pkg::*;
#(
   parameter int unsigned SEQ_LEN  = 8,
   parameter int unsigned KERNEL   = 3,
   parameter int unsigned STRIDE   = 2,
   parameter int unsigned PADDING  = 1,
   parameter int unsigned DILATION = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   output logic                     ready_in,
   input  logic [DATA_W-1:0]        input_data,
   input  logic                     last_in,
   output logic                     valid_out,
   input  logic                     ready_out,
   output logic [KERNEL*DATA_W-1:0] win_data,
   output logic [KERNEL-1:0]        win_pad_mask,
   output logic                     win_last,
   output logic                     err_len
);

   localparam int unsigned SPAN     = DILATION * (KERNEL - 1) + 1;
   localparam int unsigned PLEN     = SEQ_LEN + 2 * PADDING;
   localparam int          OUT_LEN  = pool_out_len(int'(SEQ_LEN), int'(KERNEL), int'(STRIDE),
                                                   int'(PADDING), int'(DILATION));
   localparam int unsigned OUT_N    = (OUT_LEN < 1) ? 1 : OUT_LEN;
   localparam int unsigned PW       = (PLEN > 1) ? $clog2(PLEN) : 1;
   localparam int unsigned WW       = (OUT_N > 1) ? $clog2(OUT_N + 1) : 1;
   localparam int unsigned BODY_END = PADDING + SEQ_LEN - 1;
   localparam state_e      START    = (PADDING == 0) ? BODY : LEAD;

   if (SEQ_LEN < 1 || KERNEL < 1 || STRIDE < 1 || DILATION < 1 || PADDING > KERNEL / 2 ||
       OUT_LEN < 1) begin : g_bad_params
      $fatal(1, "pool1d_window_gen: illegal parameter set");
   end

   state_e                  state;
   logic [PW-1:0]           p;
   logic [WW-1:0]           w;
   logic                    stall;
   logic                    accept;
   logic                    pad_ins;
   logic                    shift;
   logic                    emit;
   logic [KERNEL*DATA_W-1:0] tap_data;
   logic [KERNEL-1:0]        tap_pad;

   always_comb begin
      stall    = valid_out & ~ready_out;
      ready_in = ~rst & (state == BODY) & ~stall;
      accept   = valid_in & ready_in;
      pad_ins  = (state != BODY);
      shift    = pad_ins ? ~stall : accept;
      // A window completes when the position just written is the newest tap of a strided start.
      emit     = shift && (32'(p) >= SPAN - 1) && ((32'(p) - (SPAN - 1)) % STRIDE == 0) &&
                 (32'(w) < OUT_N);
   end

   pool1d_tap_shreg #(
      .SPAN     (SPAN),
      .KERNEL   (KERNEL),
      .DILATION (DILATION)
   ) u_tap_shreg (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift),
      .pad_ins  (pad_ins),
      .din      (input_data),
      .tap_data (tap_data),
      .tap_pad  (tap_pad)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= START;
         p            <= '0;
         w            <= '0;
         valid_out    <= 1'b0;
         win_last     <= 1'b0;
         win_pad_mask <= '0;
         win_data     <= '0;
         err_len      <= 1'b0;
      end else begin
         if (emit) begin
            valid_out    <= 1'b1;
            win_data     <= tap_data;
            win_pad_mask <= tap_pad;
            win_last     <= (32'(w) == OUT_N - 1);
            w            <= w + 1'b1;
         end else if (ready_out) begin
            valid_out <= 1'b0;
         end
         if (accept && ((32'(p) == BODY_END) != last_in)) err_len <= 1'b1;
         // Row wrap below must override the window increment above.
         if (shift) begin
            p <= p + 1'b1;
            case (state)
               LEAD: if (32'(p) == PADDING - 1) state <= BODY;
               BODY: begin
                  if (32'(p) == BODY_END) begin
                     if (PADDING == 0) begin
                        p <= '0;
                        w <= '0;
                     end else begin
                        state <= TRAIL;
                     end
                  end
               end
               TRAIL: begin
                  if (32'(p) == PLEN - 1) begin
                     state <= LEAD;
                     p     <= '0;
                     w     <= '0;
                  end
               end
               default: state <= START;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pool1d_window_gen.sv
// Bench for pool1d_window_gen: default-shaped and dilated instances checked against an
// index-arithmetic MaxPool1d model through a window scoreboard.
module tb_pool1d_window_gen;

   typedef struct packed {
      logic [95:0] data;
      logic [2:0]  mask;
      logic        last;
   } win_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        a_valid_in, a_ready_in, a_last_in, a_valid_out, a_ready_out, a_win_last, a_err_len;
   logic [31:0] a_input_data;
   logic [95:0] a_win_data;
   logic [2:0]  a_win_pad_mask;
   logic        b_valid_in, b_ready_in, b_last_in, b_valid_out, b_ready_out, b_win_last, b_err_len;
   logic [31:0] b_input_data;
   logic [63:0] b_win_data;
   logic [1:0]  b_win_pad_mask;

   pool1d_window_gen dut_a (
      .clk(clk), .rst(rst), .valid_in(a_valid_in), .ready_in(a_ready_in),
      .input_data(a_input_data), .last_in(a_last_in), .valid_out(a_valid_out),
      .ready_out(a_ready_out), .win_data(a_win_data), .win_pad_mask(a_win_pad_mask),
      .win_last(a_win_last), .err_len(a_err_len)
   );

   pool1d_window_gen #(
      .SEQ_LEN(8), .KERNEL(2), .STRIDE(1), .PADDING(0), .DILATION(3)
   ) dut_b (
      .clk(clk), .rst(rst), .valid_in(b_valid_in), .ready_in(b_ready_in),
      .input_data(b_input_data), .last_in(b_last_in), .valid_out(b_valid_out),
      .ready_out(b_ready_out), .win_data(b_win_data), .win_pad_mask(b_win_pad_mask),
      .win_last(b_win_last), .err_len(b_err_len)
   );

   int   checks = 0;
   int   failures = 0;
   win_t exp_a[$];
   win_t exp_b[$];
   bit   rand_bp = 1'b0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Window w starts at padded position w*s; lane l reads padded position w*s + l*d.
   function automatic win_t model_win(input logic [31:0] row[8], input int k, input int s,
                                      input int pd, input int d, input int w);
      win_t r;
      int   outl;
      int   pos;
      outl = (8 + 2 * pd - (d * (k - 1) + 1)) / s + 1;
      r = '0;
      for (int l = 0; l < k; l++) begin
         pos = w * s + l * d;
         if (pos < pd || pos >= pd + 8) begin
            r.data[l*32 +: 32] = 32'h8000_0000;
            r.mask[l] = 1'b1;
         end else begin
            r.data[l*32 +: 32] = row[pos-pd];
         end
      end
      r.last = (w == outl - 1);
      return r;
   endfunction

   // Queue every window whose newest position lies within the first n samples of the row.
   task automatic push_exp(input bit to_b, input logic [31:0] row[8], input int n);
      int k, s, pd, d, span, outl;
      k = to_b ? 2 : 3;  s = to_b ? 1 : 2;  pd = to_b ? 0 : 1;  d = to_b ? 3 : 1;
      span = d * (k - 1) + 1;
      outl = (8 + 2 * pd - span) / s + 1;
      for (int w = 0; w < outl; w++) begin
         if (w * s + span - 1 <= pd + n - 1) begin
            if (to_b) exp_b.push_back(model_win(row, k, s, pd, d, w));
            else exp_a.push_back(model_win(row, k, s, pd, d, w));
         end
      end
   endtask

   task automatic send_a(input logic [31:0] row[8], input int first, input int n,
                         input int last_idx, input int gap_pct);
      int budget;
      for (int i = first; i < first + n; i++) begin
         if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
            @(negedge clk);
            a_valid_in = 1'b0;
         end
         @(negedge clk);
         a_valid_in = 1'b1;
         a_input_data = row[i];
         a_last_in = (i == last_idx);
         #1;
         budget = 0;
         while (!a_ready_in && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
         end
         check("a_accept", a_ready_in, 1'b1);
      end
   endtask

   task automatic send_b(input logic [31:0] row[8]);
      int budget;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         b_valid_in = 1'b1;
         b_input_data = row[i];
         b_last_in = (i == 7);
         #1;
         budget = 0;
         while (!b_ready_in && budget < 200) begin
            @(negedge clk);
            #1;
            budget++;
         end
         check("b_accept", b_ready_in, 1'b1);
      end
      @(negedge clk);
      b_valid_in = 1'b0;
      b_last_in = 1'b0;
   endtask

   task automatic idle_a();
      @(negedge clk);
      a_valid_in = 1'b0;
      a_last_in = 1'b0;
   endtask

   task automatic drain(input bit to_b);
      for (int c = 0; c < 300 && (to_b ? exp_b.size() : exp_a.size()) != 0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      if (to_b) check("b_drained", exp_b.size(), 0);
      else check("a_drained", exp_a.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rand_bp) a_ready_out = ($urandom_range(0, 3) != 0);
   end

   // Scoreboard for dut_a, including hold-stability while backpressured.
   win_t a_prev;
   bit   a_hold_prev = 1'b0;
   win_t a_e;
   always @(negedge clk) begin
      #2;
      if (!rst && a_valid_out) begin
         if (a_hold_prev) begin
            check("a_hold_data", a_win_data, a_prev.data);
            check("a_hold_mask", a_win_pad_mask, a_prev.mask);
            check("a_hold_last", a_win_last, a_prev.last);
         end
         if (a_ready_out) begin
            check("a_exp_avail", exp_a.size() != 0, 1'b1);
            if (exp_a.size() != 0) begin
               a_e = exp_a.pop_front();
               check("a_win_data", a_win_data, a_e.data);
               check("a_win_mask", a_win_pad_mask, a_e.mask);
               check("a_win_last", a_win_last, a_e.last);
            end
            a_hold_prev = 1'b0;
         end else begin
            a_hold_prev = 1'b1;
            a_prev = '{data: a_win_data, mask: a_win_pad_mask, last: a_win_last};
         end
      end else begin
         a_hold_prev = 1'b0;
      end
   end

   win_t b_e;
   always @(negedge clk) begin
      #2;
      if (!rst && b_valid_out && b_ready_out) begin
         check("b_exp_avail", exp_b.size() != 0, 1'b1);
         if (exp_b.size() != 0) begin
            b_e = exp_b.pop_front();
            check("b_win_data", b_win_data, b_e.data);
            check("b_win_mask", b_win_pad_mask, b_e.mask);
            check("b_win_last", b_win_last, b_e.last);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   logic [31:0] row [8];
   logic [31:0] part [8];

   initial begin
      rst = 1'b1;
      a_valid_in = 0; a_last_in = 0; a_input_data = 0; a_ready_out = 1;
      b_valid_in = 0; b_last_in = 0; b_input_data = 0; b_ready_out = 1;
      #12;
      check("rst_a_valid_out", a_valid_out, 1'b0);
      check("rst_a_ready_in", a_ready_in, 1'b0);
      check("rst_a_win_data", a_win_data, 96'd0);
      check("rst_a_mask", a_win_pad_mask, 3'd0);
      check("rst_a_last", a_win_last, 1'b0);
      check("rst_a_err", a_err_len, 1'b0);
      check("rst_b_ready_in", b_ready_in, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Basic default row 1..8.
      for (int i = 0; i < 8; i++) row[i] = 32'(i + 1);
      push_exp(1'b0, row, 8);
      send_a(row, 0, 8, 7, 0);
      idle_a();
      drain(1'b0);
      check("s1_err_len", a_err_len, 1'b0);

      // Dilated, unpadded instance with inputs 10..17.
      for (int i = 0; i < 8; i++) row[i] = 32'(i + 10);
      push_exp(1'b1, row, 8);
      send_b(row);
      drain(1'b1);

      // Backpressure for 6 cycles once the first window is up.
      for (int i = 0; i < 8; i++) row[i] = 32'(i + 1);
      push_exp(1'b0, row, 8);
      fork
         send_a(row, 0, 8, 7, 0);
         begin
            for (int c = 0; c < 100 && !a_valid_out; c++) @(negedge clk);
            check("stall_win_seen", a_valid_out, 1'b1);
            a_ready_out = 1'b0;
            repeat (6) begin
               #1;
               check("stall_ready_in", a_ready_in, 1'b0);
               @(negedge clk);
            end
            a_ready_out = 1'b1;
         end
      join
      idle_a();
      drain(1'b0);

      // Back-to-back random rows, later ones with gaps and random backpressure.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 8; i++) row[i] = $urandom;
         push_exp(1'b0, row, 8);
         rand_bp = (r >= 2);
         send_a(row, 0, 8, 7, (r >= 2) ? 30 : 0);
      end
      idle_a();
      for (int c = 0; c < 300 && exp_a.size() != 0; c++) @(negedge clk);
      rand_bp = 1'b0;
      a_ready_out = 1'b1;
      drain(1'b0);
      check("rand_err_len", a_err_len, 1'b0);

      // Early last_in on the 5th sample; framing still follows the count.
      for (int i = 0; i < 8; i++) row[i] = $urandom;
      push_exp(1'b0, row, 8);
      check("err_before", a_err_len, 1'b0);
      send_a(row, 0, 5, 4, 0);
      idle_a();
      repeat (2) @(negedge clk);
      check("err_set", a_err_len, 1'b1);
      send_a(row, 5, 3, 4, 0);
      idle_a();
      drain(1'b0);
      check("err_sticky", a_err_len, 1'b1);

      // Reset mid-row, then a fresh row.
      for (int i = 0; i < 8; i++) part[i] = 32'(50 + i);
      push_exp(1'b0, part, 3);
      send_a(part, 0, 3, 7, 0);
      idle_a();
      drain(1'b0);
      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("rst2_valid_out", a_valid_out, 1'b0);
      check("rst2_ready_in", a_ready_in, 1'b0);
      check("rst2_win_data", a_win_data, 96'd0);
      check("rst2_err", a_err_len, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("rst2_idle_valid", a_valid_out, 1'b0);
      for (int i = 0; i < 8; i++) row[i] = 32'(i + 1);
      push_exp(1'b0, row, 8);
      send_a(row, 0, 8, 7, 0);
      idle_a();
      drain(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
